l2_arbiter: RTL and testbench

Two-port line-request arbiter directly upstream of the L2 cache. It merges I-cache miss reads and D-cache miss reads and writebacks into the single L2 request port. The arbiter grants one requester at a time, using round-robin priority on ties. It latches the granted request, drives the L2 until `mem_resp`, then returns the response to the granted L1 cache only.

---
 rtl/l2_arbiter.sv | 110 +++++++++++
 tb/tb_l2_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Two-port line-request arbiter in front of the L2: merges I-cache reads and
// D-cache reads/writebacks onto one L2 port with round-robin tie-breaking.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int MASK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  input  logic [MASK_W-1:0] d_mem_byte_enable,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  output logic [MASK_W-1:0] l2_mem_byte_enable,
  input  logic              l2_mem_resp,
  input  logic [LINE_W-1:0] l2_mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t state;
  logic   last_grant_d;
  logic   i_req;
  logic   d_req;
  logic   grant_i;

  // I wins when D is idle or when D was the previous grantee.
  always_comb begin
    i_req   = i_mem_read;
    d_req   = d_mem_read | d_mem_write;
    grant_i = i_req & (~d_req | last_grant_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_grant_d       <= 1'b1;
      i_mem_resp         <= 1'b0;
      d_mem_resp         <= 1'b0;
      i_mem_rdata        <= '0;
      d_mem_rdata        <= '0;
      l2_mem_read        <= 1'b0;
      l2_mem_write       <= 1'b0;
      l2_mem_address     <= '0;
      l2_mem_wdata       <= '0;
      l2_mem_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            l2_mem_address     <= i_mem_address;
            l2_mem_wdata       <= '0;
            l2_mem_byte_enable <= '0;
            l2_mem_read        <= 1'b1;
            l2_mem_write       <= 1'b0;
            last_grant_d       <= 1'b0;
            state              <= BUSY_I;
          end else if (d_req) begin
            // A write takes precedence when both D strobes are raised.
            l2_mem_address     <= d_mem_address;
            l2_mem_wdata       <= d_mem_wdata;
            l2_mem_byte_enable <= d_mem_byte_enable;
            l2_mem_read        <= ~d_mem_write;
            l2_mem_write       <= d_mem_write;
            last_grant_d       <= 1'b1;
            state              <= BUSY_D;
          end
        end
        BUSY_I: begin
          if (l2_mem_resp) begin
            l2_mem_read  <= 1'b0;
            l2_mem_write <= 1'b0;
            i_mem_rdata  <= l2_mem_rdata;
            i_mem_resp   <= 1'b1;
            state        <= DONE;
          end
        end
        BUSY_D: begin
          if (l2_mem_resp) begin
            if (l2_mem_read) begin
              d_mem_rdata <= l2_mem_rdata;
            end
            l2_mem_read  <= 1'b0;
            l2_mem_write <= 1'b0;
            d_mem_resp   <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          i_mem_resp <= 1'b0;
          d_mem_resp <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed and randomized bench for l2_arbiter with a transaction-level
// round-robin model of expected grants, L2 fields and returned lines.
module tb_l2_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int MASK_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_address;
  logic              i_mem_resp;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [MASK_W-1:0] d_mem_byte_enable;
  logic              d_mem_resp;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              l2_mem_read;
  logic              l2_mem_write;
  logic [ADDR_W-1:0] l2_mem_address;
  logic [LINE_W-1:0] l2_mem_wdata;
  logic [MASK_W-1:0] l2_mem_byte_enable;
  logic              l2_mem_resp;
  logic [LINE_W-1:0] l2_mem_rdata;

  int checks   = 0;
  int failures = 0;

  bit                exp_last_d;
  logic [LINE_W-1:0] exp_i_rdata;
  logic [LINE_W-1:0] exp_d_rdata;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_byte_enable(l2_mem_byte_enable),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_l2rd"}, 128'(l2_mem_read), 128'(1'b0));
    chk({tag, "_l2wr"}, 128'(l2_mem_write), 128'(1'b0));
    chk({tag, "_iresp"}, 128'(i_mem_resp), 128'(1'b0));
    chk({tag, "_dresp"}, 128'(d_mem_resp), 128'(1'b0));
    chk({tag, "_irdata"}, i_mem_rdata, exp_i_rdata);
    chk({tag, "_drdata"}, d_mem_rdata, exp_d_rdata);
  endtask

  // Applies one set of requests and serves every pending side to completion.
  task automatic round(input bit ireq, input bit drd, input bit dwr,
                       input logic [15:0] iaddr, input logic [15:0] daddr,
                       input logic [127:0] dwd, input logic [15:0] dmask,
                       input logic [127:0] rdv, input int lat, input bit spur);
    bit pi, pd, win_i;
    i_mem_read = ireq; i_mem_address = iaddr;
    d_mem_read = drd; d_mem_write = dwr; d_mem_address = daddr;
    d_mem_wdata = dwd; d_mem_byte_enable = dmask;
    pi = ireq;
    pd = drd | dwr;
    if (!pi && !pd) begin
      @(posedge clk); #1;
      chk_quiet("noreq");
    end
    while (pi || pd) begin
      win_i = pi && (!pd || exp_last_d);
      for (int k = 0; k < lat; k++) begin
        @(posedge clk); #1;
        if (win_i) begin
          chk("busy_i_rd", 128'(l2_mem_read), 128'(1'b1));
          chk("busy_i_wr", 128'(l2_mem_write), 128'(1'b0));
          chk("busy_i_addr", 128'(l2_mem_address), 128'(iaddr));
          chk("busy_i_wdata", l2_mem_wdata, 128'(0));
          chk("busy_i_mask", 128'(l2_mem_byte_enable), 128'(0));
        end else begin
          chk("busy_d_rd", 128'(l2_mem_read), 128'(!dwr));
          chk("busy_d_wr", 128'(l2_mem_write), 128'(dwr));
          chk("busy_d_addr", 128'(l2_mem_address), 128'(daddr));
          chk("busy_d_wdata", l2_mem_wdata, dwd);
          chk("busy_d_mask", 128'(l2_mem_byte_enable), 128'(dmask));
        end
        chk("busy_iresp", 128'(i_mem_resp), 128'(1'b0));
        chk("busy_dresp", 128'(d_mem_resp), 128'(1'b0));
        if (k == 0) begin
          if (win_i) i_mem_address = 16'hFFFE;
          else begin
            d_mem_address = ~daddr;
            d_mem_wdata = ~dwd;
            d_mem_byte_enable = ~dmask;
          end
        end
      end
      l2_mem_rdata = rdv;
      l2_mem_resp  = 1'b1;
      @(posedge clk); #1;
      l2_mem_resp  = spur;
      l2_mem_rdata = ~rdv;
      chk("done_l2rd", 128'(l2_mem_read), 128'(1'b0));
      chk("done_l2wr", 128'(l2_mem_write), 128'(1'b0));
      if (win_i) begin
        exp_i_rdata = rdv;
        exp_last_d  = 1'b0;
        chk("done_iresp", 128'(i_mem_resp), 128'(1'b1));
        chk("done_dresp_idle", 128'(d_mem_resp), 128'(1'b0));
        i_mem_read = 1'b0;
        pi = 1'b0;
      end else begin
        if (!dwr) exp_d_rdata = rdv;
        exp_last_d = 1'b1;
        chk("done_dresp", 128'(d_mem_resp), 128'(1'b1));
        chk("done_iresp_idle", 128'(i_mem_resp), 128'(1'b0));
        d_mem_read = 1'b0;
        d_mem_write = 1'b0;
        pd = 1'b0;
      end
      chk("done_irdata", i_mem_rdata, exp_i_rdata);
      chk("done_drdata", d_mem_rdata, exp_d_rdata);
      @(posedge clk); #1;
      l2_mem_resp = 1'b0;
      chk_quiet("after_done");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_last_d  = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    i_mem_read = 0; i_mem_address = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_address = '0;
    d_mem_wdata = '0; d_mem_byte_enable = '0;
    l2_mem_resp = 0; l2_mem_rdata = '0;
    exp_i_rdata = '0; exp_d_rdata = '0; exp_last_d = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_addr", 128'(l2_mem_address), 128'(0));
    chk("reset_wdata", l2_mem_wdata, 128'(0));
    chk("reset_mask", 128'(l2_mem_byte_enable), 128'(0));
    rst = 1'b0;

    // Lone I read, then lone D write.
    round(1, 0, 0, 16'h1230, 16'h0, '0, 16'h0, {16{8'hA5}}, 3, 0);
    round(0, 0, 1, 16'h0, 16'h4440, {4{32'hDEADBEEF}}, 16'hFFFF, {16{8'h3C}}, 3, 0);

    // Tie after reset: I then D; after a lone I, a tie goes to D first.
    do_reset();
    round(1, 1, 0, 16'h0100, 16'h0200, {4{32'h01234567}}, 16'h00FF, {4{32'h89ABCDEF}}, 2, 0);
    round(1, 0, 0, 16'h0300, 16'h0, '0, 16'h0, {4{32'h13579BDF}}, 2, 0);
    round(1, 1, 0, 16'h0400, 16'h0500, {4{32'h0F0F0F0F}}, 16'hF0F0, {4{32'h2468ACE0}}, 2, 1);

    // Read+write together is a write; I address changes mid-busy.
    round(0, 1, 1, 16'h0, 16'h6660, {4{32'hCAFEF00D}}, 16'h0F0F, {4{32'h55AA55AA}}, 3, 0);
    round(1, 0, 0, 16'h2468, 16'h0, '0, 16'h0, {4{32'h77777777}}, 4, 1);

    // Reset while BUSY_D with a late L2 response.
    d_mem_write = 1; d_mem_address = 16'h7770;
    d_mem_wdata = {4{32'h11112222}}; d_mem_byte_enable = 16'hAAAA;
    @(posedge clk); #1;
    chk("rstmid_busy_wr", 128'(l2_mem_write), 128'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d_mem_write = 0;
    l2_mem_resp = 1'b1; l2_mem_rdata = {4{32'h99999999}};
    exp_last_d = 1'b1; exp_i_rdata = '0; exp_d_rdata = '0;
    chk_quiet("rstmid");
    chk("rstmid_addr", 128'(l2_mem_address), 128'(0));
    @(posedge clk); #1;
    l2_mem_resp = 1'b0;
    chk_quiet("rstmid_late");
    @(posedge clk); #1;
    chk_quiet("rstmid_idle");
    round(1, 0, 0, 16'h0AB0, 16'h0, '0, 16'h0, {4{32'hFEEDFACE}}, 2, 0);

    for (int n = 0; n < 40; n++) begin
      round(1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom},
            int'($urandom_range(1, 4)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
